// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared constants and types for the data-memory bus arbiter
// Purpose: FSM state encodings, master indices, latency counter width and the
//          latched command record used by the arbiter.
// Ports:   none (package).
package mem_bus_arbiter_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_AUX = 1'b1;

  typedef struct packed {
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
  } cmd_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - master-side requests, completions and RAM bus bundle
// Purpose: groups the two master request ports, their grant/valid pulses, the
//          shared read-data return and the RAM (Dw*) bus.
// Ports:   m0_*/m1_*   per-master request, command, grant and valid
//          read_data   last captured read word, shared by both masters
//          dw_*        RAM address, write data, byte enables, strobes, read data
//          owner       master owning the current or last access
// Modports: slave  - the arbiter side
//           master - the environment side (masters and RAM)
interface mem_bus_arbiter_if;

  logic        m0_req;
  logic        m0_write;
  logic [31:0] m0_address;
  logic [31:0] m0_write_data;
  logic [3:0]  m0_byte_enable;
  logic        m0_gnt;
  logic        m0_valid;

  logic        m1_req;
  logic        m1_write;
  logic [31:0] m1_address;
  logic [31:0] m1_write_data;
  logic [3:0]  m1_byte_enable;
  logic        m1_gnt;
  logic        m1_valid;

  logic [31:0] read_data;
  logic        owner;

  logic [31:0] dw_address;
  logic [31:0] dw_write_data;
  logic [3:0]  dw_byte_enable;
  logic        dw_write_enable;
  logic        dw_read_enable;
  logic [31:0] dw_read_data;

  modport slave (
    input  m0_req, m0_write, m0_address, m0_write_data, m0_byte_enable,
    input  m1_req, m1_write, m1_address, m1_write_data, m1_byte_enable,
    input  dw_read_data,
    output m0_gnt, m0_valid, m1_gnt, m1_valid,
    output read_data, owner,
    output dw_address, dw_write_data, dw_byte_enable, dw_write_enable, dw_read_enable
  );

  modport master (
    output m0_req, m0_write, m0_address, m0_write_data, m0_byte_enable,
    output m1_req, m1_write, m1_address, m1_write_data, m1_byte_enable,
    output dw_read_data,
    input  m0_gnt, m0_valid, m1_gnt, m1_valid,
    input  read_data, owner,
    input  dw_address, dw_write_data, dw_byte_enable, dw_write_enable, dw_read_enable
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// rtl/mem_bus_arbiter_rr_pick2.sv - two-request round-robin picker
// Purpose: chooses one of two requesters; on a tie the one that did not win
//          last (ptr) is chosen. Purely combinational.
// Ports:   req[1:0]      request pair (bit n = master n)
//          ptr           index of the master granted last
//          winner        chosen master index
//          winner_valid  at least one request is high
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       winner,
  output logic       winner_valid
);

  always_comb begin
    winner_valid = |req;
    if (req == 2'b11) begin
      winner = ~ptr;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master arbiter and sequencer for the data-memory bus
// Purpose: round-robin grants between the CPU (master 0) and the auxiliary
//          master (master 1), latches the winning command, drives the RAM
//          strobes for one write cycle or READ_LATENCY read cycles, captures
//          read data and pulses the owner's valid.
// Ports:   iCLK  clock, rising edge
//          iRST  asynchronous active-high reset
//          bus   mem_bus_arbiter_if.slave (requests, grants, valids, RAM bus)
// Params:  READ_LATENCY  cycles ReadEnable is held before sampling (1..15)
module mem_bus_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  mem_bus_arbiter_if.slave     bus
);

  import mem_bus_arbiter_pkg::*;

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY);

  logic [1:0]       state;
  logic             ptr;
  logic [CNT_W-1:0] cnt;
  cmd_t             cmd;
  cmd_t             pick_cmd;
  logic             winner;
  logic             winner_valid;

  logic             gnt0;
  logic             gnt1;
  logic             valid0;
  logic             valid1;
  logic             we;
  logic             re;
  logic             owner;
  logic [31:0]      rdata;

  rr_pick2 u_pick (
    .req          ({bus.m1_req, bus.m0_req}),
    .ptr          (ptr),
    .winner       (winner),
    .winner_valid (winner_valid)
  );

  always_comb begin
    pick_cmd = '0;
    if (winner == MASTER_AUX) begin
      pick_cmd.write       = bus.m1_write;
      pick_cmd.address     = bus.m1_address;
      pick_cmd.write_data  = bus.m1_write_data;
      pick_cmd.byte_enable = bus.m1_byte_enable;
    end else begin
      pick_cmd.write       = bus.m0_write;
      pick_cmd.address     = bus.m0_address;
      pick_cmd.write_data  = bus.m0_write_data;
      pick_cmd.byte_enable = bus.m0_byte_enable;
    end
  end

  // Grants and valids are single-cycle pulses: cleared every cycle unless
  // the current state explicitly raises them.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state  <= S_IDLE;
      ptr    <= MASTER_AUX;
      cnt    <= '0;
      cmd    <= '0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      we     <= 1'b0;
      re     <= 1'b0;
      owner  <= 1'b0;
      rdata  <= '0;
    end else begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (winner_valid) begin
            cmd   <= pick_cmd;
            owner <= winner;
            ptr   <= winner;
            gnt0  <= (winner == MASTER_CPU);
            gnt1  <= (winner == MASTER_AUX);
            cnt   <= LAT_LOAD;
            we    <= pick_cmd.write;
            re    <= ~pick_cmd.write;
            state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cmd.write) begin
            we     <= 1'b0;
            valid0 <= (owner == MASTER_CPU);
            valid1 <= (owner == MASTER_AUX);
            state  <= S_RESP;
          end else if (cnt == CNT_W'(1)) begin
            // Last ReadEnable cycle: the RAM word is sampled on this edge.
            rdata  <= bus.dw_read_data;
            re     <= 1'b0;
            valid0 <= (owner == MASTER_CPU);
            valid1 <= (owner == MASTER_AUX);
            state  <= S_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.m0_gnt          = gnt0;
  assign bus.m1_gnt          = gnt1;
  assign bus.m0_valid        = valid0;
  assign bus.m1_valid        = valid1;
  assign bus.read_data       = rdata;
  assign bus.owner           = owner;
  assign bus.dw_address      = cmd.address;
  assign bus.dw_write_data   = cmd.write_data;
  assign bus.dw_byte_enable  = cmd.byte_enable;
  assign bus.dw_write_enable = we;
  assign bus.dw_read_enable  = re;

  latency_range: assert property (@(posedge iCLK) (READ_LATENCY >= 1) && (READ_LATENCY <= 15))
    else $error("READ_LATENCY outside 1..15");

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  localparam int RL  = 2;
  localparam int RL3 = 3;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst3 = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors    = 0;
  int miscompares = 0;

  mem_bus_arbiter_if bus ();
  mem_bus_arbiter_if bus3 ();

  mem_bus_arbiter #(.READ_LATENCY(RL))  dut  (.iCLK(clk), .iRST(rst),  .bus(bus));
  mem_bus_arbiter #(.READ_LATENCY(RL3)) dut3 (.iCLK(clk), .iRST(rst3), .bus(bus3));

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] rdata;
  } exp_t;

  exp_t expq0[$];
  exp_t expq1[$];

  logic [31:0] ram     [128];
  logic [31:0] ref_mem [128];
  logic        ram_ready = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'hDEADBEEF;
    return 32'h3C00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr(input int m);
    logic [31:0] a;
    a = $urandom;
    a[8:2] = (m == 0) ? 7'($urandom_range(0, 63)) : 7'($urandom_range(64, 127));
    a[1:0] = 2'b00;
    return a;
  endfunction

  // RAM behind the main arbiter: word-indexed by address bits 8:2.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 128; i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else if (bus.dw_write_enable) begin
      for (int b = 0; b < 4; b++)
        if (bus.dw_byte_enable[b]) ram[bus.dw_address[8:2]][8*b +: 8] <= bus.dw_write_data[8*b +: 8];
    end
  end
  assign bus.dw_read_data  = bus.dw_read_enable  ? ram[bus.dw_address[8:2]]   : 32'h0;
  assign bus3.dw_read_data = bus3.dw_read_enable ? (bus3.dw_address ^ 32'h5A5A_A5A5) : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int m, input logic req, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_write = w; bus.m0_address = a;
      bus.m0_write_data = d; bus.m0_byte_enable = be;
    end else begin
      bus.m1_req = req; bus.m1_write = w; bus.m1_address = a;
      bus.m1_write_data = d; bus.m1_byte_enable = be;
    end
  endtask

  // One master access: record the expected outcome, request, hold until
  // granted, then scramble the inputs and wait for completion.
  task automatic do_access(input int m, input int gap, input logic w, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be);
    exp_t e;
    logic got;
    int   idx;
    idx     = int'(addr[8:2]);
    e.write = w;
    e.addr  = addr;
    e.data  = data;
    e.be    = be;
    e.rdata = w ? 32'h0 : ref_mem[idx];
    if (w) ref_mem[idx] = merge(ref_mem[idx], data, be);
    if (m == 0) expq0.push_back(e); else expq1.push_back(e);

    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    drive(m, 1'b1, w, addr, data, be);
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = (m == 0) ? bus.m0_gnt : bus.m1_gnt;
    end
    chk($sformatf("m%0d_gnt_timeout", m), 32'(got), 32'd1);
    @(posedge clk); #1;
    drive(m, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = (m == 0) ? bus.m0_valid : bus.m1_valid;
    end
    chk($sformatf("m%0d_valid_timeout", m), 32'(got), 32'd1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  exp_t       cur0, cur1;
  logic       act0 = 1'b0, act1 = 1'b0;
  int         gcyc0, gcyc1;
  int         re_cnt = 0, we_cnt = 0;
  logic [1:0] prev_req = 2'b00;
  logic       last = 1'b1;
  int         gnt_order[$];

  task automatic mon_gnt(input int m);
    exp_t e;
    logic ew;
    ew = (prev_req == 2'b11) ? ~last : prev_req[1];
    chk("arb_req_seen", 32'(prev_req[m]), 32'd1);
    chk("arb_winner", 32'(m), 32'(ew));
    last = 1'(m);
    gnt_order.push_back(m);
    re_cnt = 0;
    we_cnt = 0;
    if ((m == 0 && expq0.size() == 0) || (m == 1 && expq1.size() == 0)) begin
      chk("gnt_unexpected", 32'd1, 32'd0);
    end else begin
      e = (m == 0) ? expq0.pop_front() : expq1.pop_front();
      if (m == 0) begin cur0 = e; act0 = 1'b1; gcyc0 = cyc; end
      else        begin cur1 = e; act1 = 1'b1; gcyc1 = cyc; end
      chk("gnt_addr", bus.dw_address, e.addr);
      chk("gnt_cmd", {25'd0, bus.owner, bus.dw_write_enable, bus.dw_read_enable, bus.dw_byte_enable},
          {25'd0, 1'(m), e.write, ~e.write, e.be});
      if (e.write) chk("gnt_wdata", bus.dw_write_data, e.data);
    end
  endtask

  task automatic mon_valid(input int m);
    exp_t e;
    int   g;
    if ((m == 0 && !act0) || (m == 1 && !act1)) begin
      chk("valid_unexpected", 32'd1, 32'd0);
    end else begin
      e = (m == 0) ? cur0 : cur1;
      g = (m == 0) ? gcyc0 : gcyc1;
      if (m == 0) act0 = 1'b0; else act1 = 1'b0;
      chk("latency", 32'(cyc - g), e.write ? 32'd1 : 32'(RL));
      chk("we_cycles", 32'(we_cnt), e.write ? 32'd1 : 32'd0);
      chk("re_cycles", 32'(re_cnt), e.write ? 32'd0 : 32'(RL));
      if (!e.write) chk("read_data", bus.read_data, e.rdata);
      chk("owner_hold", 32'(bus.owner), 32'(m));
      chk("addr_hold", bus.dw_address, e.addr);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("gnt_onehot", 32'(bus.m0_gnt & bus.m1_gnt), 32'd0);
        if (bus.m0_gnt) mon_gnt(0);
        if (bus.m1_gnt) mon_gnt(1);
        if (bus.dw_read_enable)  re_cnt++;
        if (bus.dw_write_enable) we_cnt++;
        if (bus.m0_valid) mon_valid(0);
        if (bus.m1_valid) mon_valid(1);
      end
      prev_req = {bus.m1_req, bus.m0_req};
    end
  end

  // ---------------- stimulus ----------------
  logic got3;

  initial begin
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    bus3.m0_req = 1'b0; bus3.m0_write = 1'b0; bus3.m0_address = '0;
    bus3.m0_write_data = '0; bus3.m0_byte_enable = '0;
    bus3.m1_req = 1'b0; bus3.m1_write = 1'b0; bus3.m1_address = '0;
    bus3.m1_write_data = '0; bus3.m1_byte_enable = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    rst3 = 1'b0;

    // Reset state, no requests, 10 quiet cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_ctl", {25'd0, bus.m0_gnt, bus.m1_gnt, bus.m0_valid, bus.m1_valid,
                      bus.dw_write_enable, bus.dw_read_enable, bus.owner}, 32'd0);
      chk("rst_rdata", bus.read_data, 32'd0);
      chk("rst_bus", bus.dw_address | bus.dw_write_data | {28'd0, bus.dw_byte_enable}, 32'd0);
    end

    // Master 0 read of a known word
    do_access(0, 0, 1'b0, 32'h1001_0004, 32'h0, 4'hF);
    chk("tp_read_deadbeef", bus.read_data, 32'hDEADBEEF);

    // Master 1 partial write, then read back
    do_access(1, 0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011);
    chk("tp_write_owner", 32'(bus.owner), 32'd1);
    chk("tp_write_be", 32'(bus.dw_byte_enable), 32'b0011);
    do_access(1, 0, 1'b0, 32'h0000_0100, 32'h0, 4'hF);

    // Both masters continuously requesting: strict alternation from master 0
    gnt_order.delete();
    fork
      begin
        for (int i = 0; i < 3; i++)
          do_access(0, 0, 1'($urandom), rand_addr(0), $urandom, 4'($urandom_range(1, 15)));
      end
      begin
        for (int i = 0; i < 3; i++)
          do_access(1, 0, 1'($urandom), rand_addr(1), $urandom, 4'($urandom_range(1, 15)));
      end
    join
    chk("alt_len", 32'(gnt_order.size()), 32'd6);
    for (int i = 0; i < gnt_order.size(); i++) chk("alt_order", 32'(gnt_order[i]), 32'(i % 2));

    // Master 1 rises during master 0's read; it must beat master 0's second access
    gnt_order.delete();
    fork
      begin
        do_access(0, 0, 1'b0, rand_addr(0), 32'h0, 4'hF);
        do_access(0, 0, 1'b0, rand_addr(0), 32'h0, 4'hF);
      end
      do_access(1, 2, 1'b0, rand_addr(1), 32'h0, 4'hF);
    join
    chk("late_len", 32'(gnt_order.size()), 32'd3);
    for (int i = 0; i < gnt_order.size(); i++) chk("late_order", 32'(gnt_order[i]), 32'(i % 2));

    // Randomized traffic from both masters
    fork
      begin
        for (int i = 0; i < 10; i++)
          do_access(0, $urandom_range(0, 3), 1'($urandom), rand_addr(0), $urandom,
                    4'($urandom_range(1, 15)));
      end
      begin
        for (int i = 0; i < 10; i++)
          do_access(1, $urandom_range(0, 3), 1'($urandom), rand_addr(1), $urandom,
                    4'($urandom_range(1, 15)));
      end
    join

    // Reset abort on the READ_LATENCY=3 instance
    @(posedge clk); #1;
    bus3.m0_req = 1'b1; bus3.m0_write = 1'b0; bus3.m0_address = 32'h0000_0040;
    bus3.m0_byte_enable = 4'hF;
    @(posedge clk); #1;
    chk("rst3_first_gnt", 32'(bus3.m0_gnt), 32'd1);
    bus3.m0_req = 1'b0;
    @(posedge clk); #1;
    chk("rst3_re_before", 32'(bus3.dw_read_enable), 32'd1);
    rst3 = 1'b1;
    #1;
    chk("rst3_abort", {25'd0, bus3.m0_gnt, bus3.m1_gnt, bus3.m0_valid, bus3.m1_valid,
                       bus3.dw_write_enable, bus3.dw_read_enable, bus3.owner}, 32'd0);
    @(negedge clk);
    rst3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst3_quiet", {28'd0, bus3.m0_valid, bus3.m1_valid, bus3.m0_gnt | bus3.m1_gnt,
                         bus3.dw_read_enable | bus3.dw_write_enable}, 32'd0);
    end
    @(posedge clk); #1;
    bus3.m0_req = 1'b1;
    bus3.m1_req = 1'b1; bus3.m1_write = 1'b0; bus3.m1_address = 32'h0000_0080;
    bus3.m1_byte_enable = 4'hF;
    got3 = 1'b0;
    for (int i = 0; i < 20 && !got3; i++) begin
      @(negedge clk);
      got3 = bus3.m0_gnt | bus3.m1_gnt;
    end
    chk("rst3_tie_winner", {30'd0, bus3.m1_gnt, bus3.m0_gnt}, 32'b01);
    @(posedge clk); #1;
    bus3.m0_req = 1'b0;
    got3 = 1'b0;
    for (int i = 0; i < 20 && !got3; i++) begin
      @(negedge clk);
      got3 = bus3.m0_valid;
    end
    chk("rst3_valid0", 32'(got3), 32'd1);
    chk("rst3_rdata0", bus3.read_data, 32'h0000_0040 ^ 32'h5A5A_A5A5);
    got3 = 1'b0;
    for (int i = 0; i < 20 && !got3; i++) begin
      @(negedge clk);
      got3 = bus3.m1_gnt;
    end
    chk("rst3_gnt1", 32'(got3), 32'd1);
    @(posedge clk); #1;
    bus3.m1_req = 1'b0;
    got3 = 1'b0;
    for (int i = 0; i < 20 && !got3; i++) begin
      @(negedge clk);
      got3 = bus3.m1_valid;
    end
    chk("rst3_valid1", 32'(got3), 32'd1);
    chk("rst3_rdata1", bus3.read_data, 32'h0000_0080 ^ 32'h5A5A_A5A5);

    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(expq0.size()), 32'd0);
    chk("q1_drained", 32'(expq1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
